// File: rtl/dma_pkg.sv
// Shared constants and FSM encoding for the DMA memory responder.
package dma_pkg;

  localparam int unsigned BURST_LEN_W = 5;
  localparam int unsigned BYTE_SHIFT  = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'b001,
    StRdBurst = 3'b010,
    StWrBurst = 3'b100
  } dma_state_e;

endpackage

// File: rtl/dma_mem_responder.sv
// Memory-side burst responder: serves DMA read bursts from, and commits write bursts to,
// an internal word array with round-robin arbitration between the two request channels.
module dma_mem_responder
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            rd_req_addr,
  input  logic [BURST_LEN_W-1:0] rd_req_len,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  output logic [DATA_WIDTH-1:0]  rd_rdata,
  output logic                   rd_valid,
  output logic                   rd_last,
  input  logic                   rd_ready,
  input  logic [31:0]            wr_req_addr,
  input  logic [BURST_LEN_W-1:0] wr_req_len,
  input  logic                   wr_req_valid,
  output logic                   wr_req_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_valid,
  input  logic                   wr_last,
  output logic                   wr_ready,
  input  logic [MEM_AW-1:0]      dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_rdata,
  output logic                   proto_err
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  dma_state_e             state_q;
  logic [MEM_AW-1:0]      idx_q;
  logic [BURST_LEN_W-1:0] cnt_q;
  logic                   last_wr_q;
  logic                   rd_valid_q;
  logic                   rd_last_q;
  logic [DATA_WIDTH-1:0]  rd_rdata_q;
  logic                   wr_ready_q;
  logic                   proto_err_q;

  logic                   is_idle;
  logic                   grant_rd;
  logic                   cnt_zero;
  logic                   mem_we;
  logic [MEM_AW-1:0]      rd_start_idx;
  logic [MEM_AW-1:0]      wr_start_idx;
  logic [MEM_AW-1:0]      idx_inc;
  logic [BURST_LEN_W-1:0] cnt_dec;

  logic unused_addr;
  assign unused_addr = ^{rd_req_addr[31:MEM_AW+BYTE_SHIFT], rd_req_addr[BYTE_SHIFT-1:0],
                         wr_req_addr[31:MEM_AW+BYTE_SHIFT], wr_req_addr[BYTE_SHIFT-1:0]};

  assign rd_start_idx = rd_req_addr[MEM_AW+BYTE_SHIFT-1:BYTE_SHIFT];
  assign wr_start_idx = wr_req_addr[MEM_AW+BYTE_SHIFT-1:BYTE_SHIFT];
  assign idx_inc      = idx_q + MEM_AW'(1);
  assign cnt_dec      = cnt_q - BURST_LEN_W'(1);
  assign cnt_zero     = (cnt_q == '0);

  // last_wr_q resets high so the read channel wins the first contested grant.
  assign is_idle      = (state_q == StIdle) && !rst;
  assign grant_rd     = rd_req_valid && (!wr_req_valid || last_wr_q);
  assign rd_req_ready = is_idle && rd_req_valid && grant_rd;
  assign wr_req_ready = is_idle && wr_req_valid && !grant_rd;

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_rdata  = rd_rdata_q;
  assign wr_ready  = wr_ready_q;
  assign proto_err = proto_err_q;
  assign dbg_rdata = mem_q[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      last_wr_q   <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_rdata_q  <= '0;
      wr_ready_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_req_ready) begin
            state_q    <= StRdBurst;
            idx_q      <= rd_start_idx;
            cnt_q      <= rd_req_len;
            last_wr_q  <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (rd_req_len == '0);
            rd_rdata_q <= mem_q[rd_start_idx];
          end else if (wr_req_ready) begin
            state_q    <= StWrBurst;
            idx_q      <= wr_start_idx;
            cnt_q      <= wr_req_len;
            last_wr_q  <= 1'b1;
            wr_ready_q <= 1'b1;
          end
        end
        StRdBurst: begin
          // Data and last only move on a handshake, so they hold through stalls.
          if (rd_ready) begin
            if (cnt_zero) begin
              state_q    <= StIdle;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
            end else begin
              idx_q      <= idx_inc;
              cnt_q      <= cnt_dec;
              rd_rdata_q <= mem_q[idx_inc];
              rd_last_q  <= (cnt_dec == '0);
            end
          end
        end
        StWrBurst: begin
          if (wr_valid) begin
            if (cnt_zero) begin
              state_q    <= StIdle;
              wr_ready_q <= 1'b0;
              if (!wr_last) proto_err_q <= 1'b1;
            end else begin
              idx_q <= idx_inc;
              cnt_q <= cnt_dec;
              if (wr_last) proto_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // State is forced to idle by reset, so no write can land while reset is active.
  assign mem_we = (state_q == StWrBurst) && wr_valid;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wr_data;
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Scoreboard bench for dma_mem_responder: randomized bursts checked against a word-array model.
module tb_dma_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_req_addr;
  logic [4:0]  rd_req_len;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_rdata;
  logic        rd_valid;
  logic        rd_last;
  logic        rd_ready;
  logic [31:0] wr_req_addr;
  logic [4:0]  wr_req_len;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_last;
  logic        wr_ready;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic        proto_err;

  dma_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_rdata     (rd_rdata),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .rd_ready     (rd_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_len   (wr_req_len),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_last      (wr_last),
    .wr_ready     (wr_ready),
    .dbg_addr     (dbg_addr),
    .dbg_rdata    (dbg_rdata),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  beat_t       exp_q[$];
  logic [31:0] mem_m [1024];
  logic        err_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a, input int i);
    return ((a >> 2) + i) & 32'h3FF;
  endfunction

  // Monitor: every accepted read beat is matched against the scoreboard head.
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("rd_stall_valid", rd_valid, 1);
        chk("rd_stall_data", rd_rdata, held_data);
        chk("rd_stall_last", rd_last, held_last);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected_beat: got data %h, no beat expected", rd_rdata);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("rd_beat_data", rd_rdata, b.data);
          chk("rd_beat_last", rd_last, b.last);
        end
      end
      stalled   = rd_valid && !rd_ready;
      held_data = rd_rdata;
      held_last = rd_last;
    end
  end

  task automatic push_read(input logic [31:0] a, input int len);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.data = mem_m[widx(a, i)];
      b.last = (i == len);
      exp_q.push_back(b);
    end
  endtask

  task automatic rd_request(input logic [31:0] a, input int len, output bit got);
    @(posedge clk); #1;
    rd_req_addr  = a;
    rd_req_len   = 5'(len);
    rd_req_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (rd_req_ready) got = 1'b1;
    end
    chk("rd_req_accept", got, 1);
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
  endtask

  task automatic wr_request(input logic [31:0] a, input int len, output bit got);
    @(posedge clk); #1;
    wr_req_addr  = a;
    wr_req_len   = 5'(len);
    wr_req_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (wr_req_ready) got = 1'b1;
    end
    chk("wr_req_accept", got, 1);
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random stalls
  task automatic do_read(input logic [31:0] a, input int len, input int mode);
    bit got;
    int beats = 0;
    push_read(a, len);
    rd_request(a, len, got);
    if (!got) return;
    for (int cyc = 0; cyc < 300 && beats <= len; cyc++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rd_ready = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      chk("rd_valid_gapless", rd_valid, 1);
      if (!rd_valid) break;
      if (rd_ready) beats++;
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    @(negedge clk);
    chk("rd_idle_after_burst", rd_valid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input int lp, input bit gaps,
                          input bit rnd, input logic [31:0] base);
    bit got;
    int beats = 0;
    wr_request(a, len, got);
    if (!got) return;
    for (int cyc = 0; cyc < 300 && beats <= len; cyc++) begin
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data  = rnd ? $urandom : base + beats;
      wr_last  = (beats == lp);
      @(negedge clk);
      chk("wr_ready_held", wr_ready, 1);
      chk("proto_err", proto_err, err_m);
      if (!wr_ready) break;
      if (wr_valid) begin
        mem_m[widx(a, beats)] = wr_data;
        if ((beats == len) != wr_last) err_m = 1'b1;
        beats++;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    @(negedge clk);
    chk("wr_idle_after_burst", wr_ready, 0);
    chk("proto_err_end", proto_err, err_m);
    for (int i = 0; i <= len; i++) begin
      dbg_addr = 10'(widx(a, i));
      #1;
      chk("dbg_readback", dbg_rdata, mem_m[widx(a, i)]);
    end
  endtask

  // Both request channels raised together; single-beat read and write to distinct words.
  task automatic do_dual(input logic [31:0] ra, input logic [31:0] wa);
    bit rg = 0, wg = 0, wb = 0;
    int first = 0;
    push_read(ra, 0);
    @(posedge clk); #1;
    rd_req_addr = ra; rd_req_len = 5'd0; rd_req_valid = 1'b1;
    wr_req_addr = wa; wr_req_len = 5'd0; wr_req_valid = 1'b1;
    rd_ready = 1'b1; wr_valid = 1'b1; wr_last = 1'b1; wr_data = $urandom;
    for (int c = 0; c < 30 && !(rg && wb); c++) begin
      @(negedge clk);
      if (rd_req_ready && wr_req_ready) chk("arb_exclusive", 1, 0);
      if (rd_req_ready) begin rg = 1; if (first == 0) first = 1; end
      if (wr_req_ready) begin wg = 1; if (first == 0) first = 2; end
      if (wr_valid && wr_ready) begin mem_m[widx(wa, 0)] = wr_data; wb = 1; end
      @(posedge clk); #1;
      if (rg) rd_req_valid = 1'b0;
      if (wg) wr_req_valid = 1'b0;
      if (wb) wr_valid = 1'b0;
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("arb_read_first", first, 1);
    chk("arb_read_granted", rg, 1);
    chk("arb_write_granted", wg, 1);
    chk("arb_write_beat", wb, 1);
    dbg_addr = 10'(widx(wa, 0));
    #1;
    chk("arb_write_data", dbg_rdata, mem_m[widx(wa, 0)]);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; rd_ready = 1'b0;
    wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
    wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_rdata", rd_rdata, 0);
    chk("rst_rd_req_ready", rd_req_ready, 0);
    chk("rst_wr_req_ready", wr_req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_proto_err", proto_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill the whole array so every later read has a known model value.
    for (int b = 0; b < 32; b++) do_write(32'(b * 128), 31, 31, 1'b0, 1'b1, 32'h0);

    // Array contents must survive reset; round-robin restarts with read priority.
    pulse_reset();
    do_dual(32'h0000_0010, 32'h0000_0020);
    do_dual(32'h0000_0030, 32'h0000_0040);

    do_write(32'h100, 7, 7, 1'b0, 1'b0, 32'h100);
    do_read(32'h100, 7, 0);
    do_read(32'h100, 7, 1);
    do_write(32'h200, 7, 7, 1'b0, 1'b0, 32'hA0);
    do_write(32'hFF8, 3, 3, 1'b0, 1'b1, 32'h0);
    do_read(32'hFF8, 3, 0);
    do_read(32'h5A5A_5FFB, 5, 2);

    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) do_read($urandom, len, 2);
      else do_write($urandom, len, len, 1'b1, 1'b1, 32'h0);
    end

    // Early wr_last on beat 3 of 8: all beats still land, error is sticky.
    do_write(32'h300, 7, 2, 1'b0, 1'b0, 32'hE0);
    chk("proto_err_sticky", proto_err, 1);

    // Reset in the middle of a read burst.
    push_read(32'h100, 7);
    rd_request(32'h100, 7, got);
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_last", rd_last, 0);
    chk("midrst_rd_req_ready", rd_req_ready, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    chk("midrst_proto_err", proto_err, 0);
    exp_q.delete();
    err_m = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_read(32'h100, 7, 0);
    do_read(32'h300, 7, 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
